// File: rtl/reg_window_ctrl.sv
// Sliding register-window controller: tracks the window base and resident frames,
// and spills/fills the oldest WIN_STEP physical registers through a word-wide memory port.
module reg_window_ctrl #(
    parameter int          NUM_PHYS   = 32,
    parameter int          WIN_STEP   = 4,
    parameter int          MAX_RES    = 7,
    parameter logic [15:0] SPILL_BASE = 16'hF000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  win_op,
    output logic                        win_busy,
    output logic                        win_done,
    output logic                        win_fault,
    output logic [$clog2(NUM_PHYS)-1:0] win_index,
    output logic [$clog2(NUM_PHYS)-1:0] phys_sel,
    input  logic [15:0]                 phys_rd_data,
    output logic                        phys_we,
    output logic [15:0]                 phys_wr_data,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [15:0]                 mem_addr,
    output logic [15:0]                 mem_wdata,
    input  logic [15:0]                 mem_rdata,
    input  logic                        mem_ack
);
    localparam int IW = $clog2(NUM_PHYS);
    localparam int KW = $clog2(WIN_STEP);
    localparam int RW = $clog2(MAX_RES + 1);
    localparam logic [IW-1:0] STEP_I    = IW'(WIN_STEP);
    localparam logic [IW-1:0] SPILL_OFS = IW'(WIN_STEP * (MAX_RES - 1));
    localparam logic [15:0]   STEP_SP   = 16'(WIN_STEP);
    localparam logic [RW-1:0] MAX_R     = RW'(MAX_RES);
    localparam logic [RW-1:0] ONE_R     = RW'(1);
    localparam logic [KW-1:0] K_LAST    = KW'(WIN_STEP - 1);

    typedef enum logic [2:0] {IDLE, SPILL, FILL, FILL_WR, COMMIT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] index, index_n;
    logic [RW-1:0] resident, resident_n;
    logic [15:0]   sp, sp_n;
    logic [15:0]   spilled, spilled_n;
    logic [KW-1:0] k, k_n;
    logic [15:0]   fill_data, fill_data_n;
    logic          was_fill, was_fill_n;
    logic          done_r, done_n;
    logic          fault_r, fault_n;

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            resident  <= ONE_R;
            sp        <= SPILL_BASE;
            spilled   <= 16'd0;
            k         <= '0;
            fill_data <= 16'd0;
            was_fill  <= 1'b0;
            done_r    <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            state     <= state_n;
            index     <= index_n;
            resident  <= resident_n;
            sp        <= sp_n;
            spilled   <= spilled_n;
            k         <= k_n;
            fill_data <= fill_data_n;
            was_fill  <= was_fill_n;
            done_r    <= done_n;
            fault_r   <= fault_n;
        end
    end

    // Next-state logic; win_done is registered so it lands in the COMMIT cycle.
    always_comb begin
        state_n     = state;
        index_n     = index;
        resident_n  = resident;
        sp_n        = sp;
        spilled_n   = spilled;
        k_n         = k;
        fill_data_n = fill_data;
        was_fill_n  = was_fill;
        done_n      = 1'b0;
        fault_n     = 1'b0;
        case (state)
            IDLE: begin
                if (win_op == 2'b10) begin
                    if (resident < MAX_R) begin
                        index_n    = index + STEP_I;
                        resident_n = resident + ONE_R;
                        done_n     = 1'b1;
                    end else begin
                        k_n        = '0;
                        was_fill_n = 1'b0;
                        state_n    = SPILL;
                    end
                end else if (win_op == 2'b01) begin
                    if (resident > ONE_R) begin
                        index_n    = index - STEP_I;
                        resident_n = resident - ONE_R;
                        done_n     = 1'b1;
                    end else if (spilled != 16'd0) begin
                        k_n        = '0;
                        was_fill_n = 1'b1;
                        state_n    = FILL;
                    end else begin
                        fault_n = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SPILL: begin
                if (mem_ack) begin
                    k_n = k + KW'(1);
                    if (k == K_LAST) begin
                        state_n = COMMIT;
                        done_n  = 1'b1;
                    end else begin
                        state_n = SPILL;
                    end
                end else begin
                    state_n = SPILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    fill_data_n = mem_rdata;
                    state_n     = FILL_WR;
                end else begin
                    state_n = FILL;
                end
            end
            FILL_WR: begin
                k_n = k + KW'(1);
                if (k == K_LAST) begin
                    state_n = COMMIT;
                    done_n  = 1'b1;
                end else begin
                    state_n = FILL;
                end
            end
            COMMIT: begin
                if (was_fill) begin
                    index_n   = index - STEP_I;
                    sp_n      = sp - STEP_SP;
                    spilled_n = spilled - 16'd1;
                end else begin
                    index_n   = index + STEP_I;
                    sp_n      = sp + STEP_SP;
                    spilled_n = (spilled != 16'hFFFF) ? spilled + 16'd1 : spilled;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Transfer-port decode; spill data passes straight through from the register file.
    always_comb begin
        phys_sel     = '0;
        phys_we      = 1'b0;
        phys_wr_data = 16'd0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 16'd0;
        mem_wdata    = 16'd0;
        case (state)
            SPILL: begin
                phys_sel  = index - SPILL_OFS + IW'(k);
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp + 16'(k);
                mem_wdata = phys_rd_data;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = sp - 16'd1 - 16'(k);
            end
            FILL_WR: begin
                phys_we      = 1'b1;
                phys_sel     = index - STEP_I + IW'(WIN_STEP - 1) - IW'(k);
                phys_wr_data = fill_data;
            end
            default: phys_we = 1'b0;
        endcase
    end

    assign win_busy  = (state != IDLE);
    assign win_done  = done_r;
    assign win_fault = fault_r;
    assign win_index = index;

endmodule
